// File: rtl/divu_pkg.sv
// divu_pkg: shared function codes, FSM state encoding and default width for the divider.
// The ZERO state exists only when DIVU_ZERO_DETECT_EN is defined.
package divu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef DIVU_ZERO_DETECT_EN
    , ZERO
`endif
  } state_t;
endpackage

// File: rtl/divu_step.sv
// divu_step: one restoring-division iteration on a WIDTH+1-bit shifted partial remainder.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   part,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_part,
  output logic             q_bit
);
  logic [WIDTH+1:0] diff;
  assign diff      = {1'b0, part} - {2'b0, divisor};
  assign q_bit     = ~diff[WIDTH+1];
  assign next_part = q_bit ? WIDTH'(diff) : part[WIDTH-1:0];
endmodule

// File: rtl/divu_unit.sv
// divu_unit: multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIVU_ZERO_DETECT_EN short-circuits a zero divisor in one cycle and flags it.
module divu_unit
  import divu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] part;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] next_part;
  logic             q_bit;
  // acc shifts dividend bits out of the top while quotient bits enter at the bottom
  divu_step #(.WIDTH(WIDTH)) u_step (
    .part      ({part, acc[WIDTH-1]}),
    .divisor   (dvs),
    .next_part (next_part),
    .q_bit     (q_bit)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      dvs       <= '0;
      part      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DIVU_ZERO_DETECT_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (Signal == FN_DIVU) begin
          acc  <= dataA;
          dvs  <= dataB;
          part <= '0;
          cnt  <= '0;
          busy <= 1'b1;
`ifdef DIVU_ZERO_DETECT_EN
          state <= (dataB == '0) ? ZERO : RUN;
`else
          state <= RUN;
`endif
        end
        RUN: begin
          acc  <= {acc[WIDTH-2:0], q_bit};
          part <= next_part;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= {acc[WIDTH-2:0], q_bit};
            remainder <= next_part;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef DIVU_ZERO_DETECT_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
`ifdef DIVU_ZERO_DETECT_EN
        ZERO: begin
          quotient    <= '1;
          remainder   <= acc;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
`ifndef DIVU_ZERO_DETECT_EN
  assign div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_divu_unit.sv
// tb_divu_unit: directed scoreboard bench for divu_unit (WIDTH=32), either DIVU_ZERO_DETECT_EN setting.
module tb_divu_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;
`ifdef DIVU_ZERO_DETECT_EN
  localparam int   ZLAT  = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int   ZLAT  = 32;
  localparam logic ZFLAG = 1'b0;
`endif
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, bc = 0, dn = 0;
  divu_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    dataA = a;
    dataB = b;
    Signal = 6'd27;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.z   = (b == 0) ? ZFLAG : 1'b0;
    e.lat = (b == 0) ? ZLAT : 32;
    sb.push_back(e);
  endtask
  task automatic accept();
    @(posedge clk);
    #1;
    cyc = 0;
    dn = 0;
    bc = busy ? 1 : 0;
    Signal = 6'd0;
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) bc++;
    if (done) dn++;
  endtask
  task automatic wait_done(input string tag);
    exp_t e;
    while (!done && cyc < 200) tick();
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, cyc, e.lat);
      chk({tag, "_busy_cycles"}, bc, e.lat);
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dbz"}, div_by_zero, e.z);
      chk({tag, "_busy_low"}, busy, 0);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, quotient, 0);
    chk({tag, "_r"}, remainder, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask
  initial begin
    reset = 1'b0;
    Signal = 6'd0;
    dataA = '0;
    dataB = '0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(100, 7);
    accept();
    wait_done("d100_7");
    tick();
    chk("done_pulse", done, 0);
    @(negedge clk);
    drive(32'hFFFF_FFFF, 1);
    accept();
    wait_done("dmax_1");
    @(negedge clk);
    drive(3, 32'h8000_0000);
    accept();
    wait_done("d3_msb");
    @(negedge clk);
    drive(5, 0);
    accept();
    wait_done("d5_0");
    @(negedge clk);
    drive(100, 7);
    accept();
    chk("hold_q", quotient, 32'hFFFF_FFFF);
    chk("hold_dbz", div_by_zero, ZFLAG);
    repeat (9) tick();
    @(negedge clk);
    dataA = 20;
    dataB = 3;
    Signal = 6'd27;
    tick();
    Signal = 6'd0;
    chk("hold_r", remainder, 5);
    wait_done("ignored");
    @(negedge clk);
    drive(20, 3);
    accept();
    wait_done("b2b");
    @(negedge clk);
    drive(100, 7);
    accept();
    repeat (14) tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    sb.delete();
    repeat (3) tick();
    chk("abort_no_done", dn, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(9, 4);
    accept();
    wait_done("d9_4");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
